// File: rtl/lm70_frame_reader.sv
// lm70_frame_reader
//   SPI master for the LM70 temperature sensor. Runs one complete read frame:
//   cs_n low, FRAME_BITS sck pulses, cs_n high. It captures the TEMP_BITS-wide
//   two's-complement temperature field, MSB first, from the top of the frame.
//   The result is presented as a held sample with a one-cycle valid strobe.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start        request one frame (ignored while busy)
//   miso         sensor SI/O data; sampled on the edge that raises sck
//   cs_n         sensor chip select, active low
//   sck          SPI clock, idles low
//   busy         high from frame start until sample_valid pulses
//   sample_valid one-cycle strobe; temp_raw/temp_deg just updated
//   temp_raw     signed raw field, LSB = 0.25 degC
//   temp_deg     signed integer degC, floor(temp_raw / 4)
module lm70_frame_reader #(
  parameter int CLK_DIV    = 2,
  parameter int FRAME_BITS = 16,
  parameter int TEMP_BITS  = 11,
  parameter int AUTO       = 1,
  parameter int INTERVAL   = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        miso,
  output logic                        cs_n,
  output logic                        sck,
  output logic                        busy,
  output logic                        sample_valid,
  output logic signed [TEMP_BITS-1:0] temp_raw,
  output logic signed [8:0]           temp_deg
);

  // The divider covers one sck half-period in SETUP/SHIFT and the longer
  // closing gap in HOLD (2*CLK_DIV-1 cycles). With the single DONE cycle, this
  // puts the cs_n rise at t0 + CLK_DIV*(2*FRAME_BITS+2).
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(FRAME_BITS);
  localparam int IW = $clog2(INTERVAL);

  localparam logic [DW-1:0] HALF_END = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] HOLD_END = DW'(2 * CLK_DIV - 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
  localparam logic [IW-1:0] IV_END   = IW'(INTERVAL - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t                       state;
  logic [DW-1:0]                div;
  logic [BW-1:0]                bit_cnt;
  logic [FRAME_BITS-1:0]        shreg;
  logic [IW-1:0]                iv_cnt;
  logic                         expire;
  logic                         go;
  logic signed [TEMP_BITS-1:0]  field;
  logic signed [TEMP_BITS-1:0]  field_q;

  assign expire  = (iv_cnt == IV_END);
  assign go      = start || ((AUTO != 0) && expire);
  assign field   = shreg[FRAME_BITS-1 -: TEMP_BITS];
  assign field_q = field >>> 2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      div          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      iv_cnt       <= '0;
      cs_n         <= 1'b1;
      sck          <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      temp_raw     <= '0;
      temp_deg     <= '0;
    end else begin
      sample_valid <= 1'b0;

      // The interval counter restarts at every frame start. An expiry that
      // lands outside IDLE is simply lost; the counter still wraps.
      if (AUTO != 0) begin
        if (expire || (state == IDLE && go)) iv_cnt <= '0;
        else                                 iv_cnt <= iv_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (go) begin
            state   <= SETUP;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            div     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        SETUP: begin
          // The end of setup is the first rising sck edge.
          if (div == HALF_END) begin
            div   <= '0;
            sck   <= 1'b1;
            shreg <= {shreg[FRAME_BITS-2:0], miso};
            state <= SHIFT;
          end else begin
            div <= div + 1'b1;
          end
        end
        SHIFT: begin
          if (div == HALF_END) begin
            div <= '0;
            if (!sck) begin
              sck   <= 1'b1;
              shreg <= {shreg[FRAME_BITS-2:0], miso};
            end else begin
              sck <= 1'b0;
              if (bit_cnt == LAST_BIT) state   <= HOLD;
              else                     bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        HOLD: begin
          if (div == HOLD_END) begin
            div   <= '0;
            state <= DONE;
          end else begin
            div <= div + 1'b1;
          end
        end
        DONE: begin
          // Frame closes here. IDLE can start the next frame on the following
          // edge, so cs_n stays high for one cycle between back-to-back frames.
          state        <= IDLE;
          cs_n         <= 1'b1;
          busy         <= 1'b0;
          sample_valid <= 1'b1;
          temp_raw     <= field;
          temp_deg     <= 9'(field_q);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lm70_frame_reader.sv
// Testbench for lm70_frame_reader. There are two instances:
//   ch0: CLK_DIV=2, AUTO=0  (start-driven frames, hold-start, mid-frame reset)
//   ch1: CLK_DIV=5, AUTO=1, INTERVAL=200 (auto grid, ignored/coincident starts)
// A sensor model shifts each frame out on miso. It also pushes the expected
// sample into a scoreboard. The stimulus pushes the expected frame start
// cycles. A monitor compares everything against those queues.
module tb_lm70_frame_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst0_n, rst1_n, start0, start1;
  logic [1:0]       miso = '0;
  logic [1:0]       cs_n, sck, busy, sv;
  logic [1:0][10:0] raw;
  logic [1:0][8:0]  deg;
  logic [1:0]       rstv;
  assign rstv = {rst1_n, rst0_n};

  lm70_frame_reader #(.CLK_DIV(2), .FRAME_BITS(16), .TEMP_BITS(11), .AUTO(0), .INTERVAL(1024)) dut (
    .clk(clk), .rst_n(rst0_n), .start(start0), .miso(miso[0]),
    .cs_n(cs_n[0]), .sck(sck[0]), .busy(busy[0]), .sample_valid(sv[0]),
    .temp_raw(raw[0]), .temp_deg(deg[0]));

  lm70_frame_reader #(.CLK_DIV(5), .FRAME_BITS(16), .TEMP_BITS(11), .AUTO(1), .INTERVAL(200)) dut_a (
    .clk(clk), .rst_n(rst1_n), .start(start1), .miso(miso[1]),
    .cs_n(cs_n[1]), .sck(sck[1]), .busy(busy[1]), .sample_valid(sv[1]),
    .temp_raw(raw[1]), .temp_deg(deg[1]));

  typedef struct {
    logic [10:0] raw;
    int          deg;
    int          t_done;
  } exp_t;

  exp_t sb [2][$];
  int   st_q [2][$];
  logic [15:0] dir_q [$] = '{16'h0C80, 16'hF380, 16'hFFE0};

  int n_vec = 0, n_bad = 0;
  bit fin = 0, fin_done = 0;

  function automatic int cdiv(input int g);
    return (g == 0) ? 2 : 5;
  endfunction

  // Reference: the top 11 frame bits form a signed quarter-degree count.
  // temp_deg is its floor division by 4.
  function automatic void ref_model(input logic [15:0] f, output logic [10:0] r, output int d);
    int v;
    v = int'(f >> 5);
    if (v >= 1024) v = v - 2048;
    r = 11'(v);
    d = (v >= 0) ? v / 4 : -((-v + 3) / 4);
  endfunction

  // ---------------- sensor model + sample scoreboard push ----------------
  logic [15:0] frm [2];
  int          bidx [2];
  logic [1:0]  scs = '1, ssck = '0;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rstv[g] && scs[g] && !cs_n[g]) begin
        exp_t e;
        if (g == 0 && dir_q.size() > 0) frm[g] = dir_q.pop_front();
        else                            frm[g] = 16'($urandom);
        bidx[g] = 15;
        miso[g] = frm[g][15];
        ref_model(frm[g], e.raw, e.deg);
        e.t_done = cyc + cdiv(g) * 34;
        sb[g].push_back(e);
      end else if (!cs_n[g] && ssck[g] && !sck[g]) begin
        if (bidx[g] > 0) bidx[g] = bidx[g] - 1;
        miso[g] = frm[g][bidx[g]];
      end
      scs[g]  = cs_n[g];
      ssck[g] = sck[g];
    end
  end

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  logic [1:0]       pcs = '1, psck = '0;
  int               t0m [2];
  int               rises [2];
  logic [1:0][10:0] last_raw = '0;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rstv[g]) begin
        chk("rst_cs_n", int'(cs_n[g]), 1);
        chk("rst_sck", int'(sck[g]), 0);
        chk("rst_busy", int'(busy[g]), 0);
        chk("rst_valid", int'(sv[g]), 0);
        chk("rst_raw", int'(raw[g]), 0);
        chk("rst_deg", int'(deg[g]), 0);
        last_raw[g] = '0;
        sb[g].delete();
      end else begin
        if (pcs[g] && !cs_n[g]) begin
          t0m[g]   = cyc;
          rises[g] = 0;
          chk("busy_at_start", int'(busy[g]), 1);
          chk("held_raw", int'(raw[g]), int'(last_raw[g]));
          if (st_q[g].size() == 0) chk("frame_start_unexpected", cyc, -1);
          else                     chk("frame_start_cycle", cyc, st_q[g].pop_front());
        end
        if (!psck[g] && sck[g]) begin
          rises[g] = rises[g] + 1;
          if (rises[g] == 1) chk("first_sck_rise", cyc - t0m[g], cdiv(g));
        end
        if (sv[g]) begin
          if (sb[g].size() == 0) begin
            chk("valid_unexpected", cyc, -1);
          end else begin
            exp_t e;
            e = sb[g].pop_front();
            chk("temp_raw", int'(raw[g]), int'(e.raw));
            chk("temp_deg", int'($signed(deg[g])), e.deg);
            chk("valid_cycle", cyc, e.t_done);
            chk("sck_pulses", rises[g], 16);
            chk("done_cs_n", int'(cs_n[g]), 1);
            chk("done_busy", int'(busy[g]), 0);
            last_raw[g] = e.raw;
          end
        end
      end
      pcs[g]  = cs_n[g];
      psck[g] = sck[g];
    end
    if (fin && !fin_done) begin
      for (int g = 0; g < 2; g++) begin
        chk("pending_samples", sb[g].size(), 0);
        chk("pending_starts", st_q[g].size(), 0);
      end
      fin_done = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(input bit expect_frame);
    @(negedge clk);
    start0 = 1'b1;
    if (expect_frame) st_q[0].push_back(cyc + 1);
    @(negedge clk);
    start0 = 1'b0;
  endtask

  initial begin
    int n, ra;
    rst0_n = 1'b0; rst1_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    fork
      begin
        repeat (3) @(negedge clk);
        rst0_n = 1'b1;
        repeat (2) @(negedge clk);
        // +25.0C, then starts during busy must not restart or queue a frame.
        pulse_start(1);
        repeat (20) @(negedge clk);
        pulse_start(0);
        repeat (15) @(negedge clk);
        pulse_start(0);
        repeat (40) @(negedge clk);
        // -25.0C and -0.25C
        for (int i = 0; i < 2; i++) begin
          pulse_start(1);
          repeat (75) @(negedge clk);
        end
        // start held for 200 cycles: frames back to back, one idle cycle apart.
        @(negedge clk);
        start0 = 1'b1;
        n = cyc;
        st_q[0].push_back(n + 1);
        st_q[0].push_back(n + 70);
        st_q[0].push_back(n + 139);
        repeat (200) @(negedge clk);
        start0 = 1'b0;
        repeat (80) @(negedge clk);
        // Reset while sck is high after the 7th rise.
        pulse_start(1);
        repeat (26) @(negedge clk);
        @(posedge clk);
        #1 rst0_n = 1'b0;
        repeat (3) @(negedge clk);
        rst0_n = 1'b1;
        repeat (3) @(negedge clk);
        pulse_start(1);
        repeat (75) @(negedge clk);
        // Random frames with a stray start in the middle of each.
        for (int i = 0; i < 6; i++) begin
          pulse_start(1);
          repeat (20) @(negedge clk);
          pulse_start(0);
          repeat (50 + $urandom_range(0, 10)) @(negedge clk);
        end
      end
      begin
        repeat (5) @(negedge clk);
        rst1_n = 1'b1;
        ra = cyc;
        for (int k = 1; k <= 5; k++) st_q[1].push_back(ra + 200 * k);
        // Starts during the first auto frame are ignored.
        while (cyc < ra + 250) @(negedge clk);
        start1 = 1'b1; @(negedge clk); start1 = 1'b0;
        while (cyc < ra + 300) @(negedge clk);
        start1 = 1'b1; @(negedge clk); start1 = 1'b0;
        // A start sampled on the same edge as an expiry gives one frame.
        while (cyc < ra + 599) @(negedge clk);
        start1 = 1'b1; @(negedge clk); start1 = 1'b0;
        while (cyc < ra + 1185) @(negedge clk);
      end
    join
    fin = 1;
    for (int i = 0; i < 10 && !fin_done; i++) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
